keypad_scan_encoder: RTL and testbench
======================================

Name: keypad_scan_encoder

Overview:
- Scans a 4x4 active-low matrix keypad, synchronises and debounces it, and encodes each press as ASCII.
- Produces the btn_valid/btn_char stream that the calculator FSM consumes: one single-cycle btn_valid pulse per debounced press.
- Sits between the keypad pins and the calculator FSM.
- Key map (row,col), both indices 0..3:
  - row 0: '1' '2' '3' '+'
  - row 1: '4' '5' '6' '-'
  - row 2: '7' '8' '9' '*'
  - row 3: 'C' '0' 8'h08 (BACKSPACE) '='

Parameters:
- SCAN_DIV, 1000: clock cycles each row is driven; must be >=4.
- DEBOUNCE_FRAMES, 4: consecutive identical frames required to accept a press or a release; must be >=2.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- kp_col  input  4  keypad columns, active-low (pulled up), asynchronous.
- kp_row  output  4  row drive, active-low one-hot.
- btn_valid  output  1  one-cycle pulse per accepted key press.
- btn_char  output  8  ASCII code of the last accepted key; valid while btn_valid=1; holds its value afterwards.
- key_held  output  1  high while an accepted key has not yet been debounced as released.

Behaviour:
- Reset (synchronous, rst=1 on a clk edge):
  - kp_row=4'b1110, btn_valid=0, btn_char=8'h00, key_held=0.
  - Synchroniser=4'hF, row_idx=0, div_cnt=0, frame accumulator cleared, debounce FSM=IDLE.
  - A reset asserted mid-operation discards any pending or held key.
- Synchroniser: 2-flop on kp_col; all downstream logic uses only the synchronised value.
- Scan timing:
  - div_cnt counts 0..SCAN_DIV-1; kp_row = ~(1<<row_idx).
  - When div_cnt==SCAN_DIV-1, sample the synchronised columns for row_idx, then row_idx increments mod 4 and div_cnt wraps to 0.
  - Sampling at the last cycle covers settling time plus synchroniser latency.
- Frame accumulator:
  - Per frame (rows 0..3), count pressed keys, saturating at 2, and record code=row*4+col of a pressed key.
  - Frame result at the row-3 sample is one of: NONE (count 0), SINGLE(code) (count 1), MULTI (count 2).
  - Accumulator clears for the next frame.
  - One frame = 4*SCAN_DIV cycles.
- Debounce FSM, evaluated only on frame completion; cnt is a frame counter.
  - IDLE:
    - SINGLE(c): cand=c, cnt=1, go to PRESS_CHK.
    - Otherwise stay in IDLE.
  - PRESS_CHK:
    - SINGLE(cand): cnt+1. When cnt+1==DEBOUNCE_FRAMES, go to HELD, pulse btn_valid and load btn_char=map(cand).
    - SINGLE(other): cand=other, cnt=1, stay in PRESS_CHK.
    - NONE or MULTI: go to IDLE, no output.
  - HELD:
    - NONE: cnt=1, go to REL_CHK.
    - SINGLE or MULTI (any code): stay in HELD, no emission. No auto-repeat; rollover is ignored.
  - REL_CHK:
    - NONE: cnt+1. When cnt+1==DEBOUNCE_FRAMES, go to IDLE.
    - SINGLE or MULTI: return to HELD.
- Output timing:
  - btn_valid is registered. It is high for exactly the one cycle following the row-3 sample edge of the accepting frame; never two consecutive cycles.
  - btn_char updates in that same cycle.
- key_held = (state==HELD or REL_CHK), registered.
- Press-to-pulse latency: DEBOUNCE_FRAMES full frames of stable single-key sampling, plus 1 cycle.

Test Plan:
(Bench models the matrix: kp_col[c]=0 iff some pressed key (r,c) has kp_row[r]=0. Use SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=16 cycles.)
1. Reset: rst=1 for 2 cycles -> kp_row=1110, btn_valid=0, btn_char=00, key_held=0. After release, kp_row steps 1110->1101->1011->0111 every 4 cycles and wraps.
2. Hold '5' (r1,c1) for 12 frames -> exactly one btn_valid pulse with btn_char=8'h35; key_held=1 from the pulse cycle on. After release, key_held=0 after 3 NONE frames.
3. Bounce '=' with pattern press1/release1/press1/release1 frames, then steady press -> no pulse until 3 consecutive pressed frames; then one pulse with btn_char=8'h3D.
4. '1' and '2' pressed together for 5 frames -> no pulse. Then release '2' with '1' held for 3 frames -> one pulse with btn_char=8'h31.
5. After '+' accepted (8'h2B): release 2 frames, re-press 5 frames -> no second pulse. Then release 3 frames and press 3 frames -> second pulse 8'h2B.
6. Full map and reset mid-HELD:
   - Each of the 16 keys pressed in turn yields its mapped code; BACKSPACE -> 8'h08, 'C' -> 8'h43.
   - Asserting rst while in HELD with the key still held -> key_held=0 immediately after reset; a new pulse follows 3 frames after rst drops.

Source files
------------

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder
//   Scans a 4x4 active-low matrix keypad one row at a time, synchronises the
//   column inputs, reduces each full scan to a frame result (no key, one key,
//   several keys), debounces frame results and emits one btn_valid pulse with
//   the ASCII code of each accepted key press.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   kp_col     keypad columns, active-low, asynchronous to clk
//   kp_row     row drive, active-low one-hot
//   btn_valid  one-cycle pulse per accepted key press
//   btn_char   ASCII code of the last accepted key (held after the pulse)
//   key_held   high while an accepted key has not been debounced as released
module keypad_scan_encoder #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] kp_col,
  output logic [3:0] kp_row,
  output logic       btn_valid,
  output logic [7:0] btn_char,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  // Adds the pressed keys of one row to the running count, saturating at 2.
  function automatic logic [1:0] merge_count(input logic [1:0] acc, input logic [3:0] hits);
    logic [2:0] sum;
    sum = {1'b0, acc} + {2'b00, hits[0]} + {2'b00, hits[1]}
        + {2'b00, hits[2]} + {2'b00, hits[3]};
    return (sum >= 3'd2) ? 2'd2 : sum[1:0];
  endfunction

  // Lowest pressed column; only meaningful when exactly one key is down.
  function automatic logic [1:0] first_col(input logic [3:0] hits);
    if (hits[0])      return 2'd0;
    else if (hits[1]) return 2'd1;
    else if (hits[2]) return 2'd2;
    else              return 2'd3;
  endfunction

  function automatic logic [7:0] key_map(input logic [3:0] code);
    case (code)
      4'd0:  return 8'h31;  // '1'
      4'd1:  return 8'h32;  // '2'
      4'd2:  return 8'h33;  // '3'
      4'd3:  return 8'h2B;  // '+'
      4'd4:  return 8'h34;  // '4'
      4'd5:  return 8'h35;  // '5'
      4'd6:  return 8'h36;  // '6'
      4'd7:  return 8'h2D;  // '-'
      4'd8:  return 8'h37;  // '7'
      4'd9:  return 8'h38;  // '8'
      4'd10: return 8'h39;  // '9'
      4'd11: return 8'h2A;  // '*'
      4'd12: return 8'h43;  // 'C'
      4'd13: return 8'h30;  // '0'
      4'd14: return 8'h08;  // backspace
      default: return 8'h3D;  // '='
    endcase
  endfunction

  // ---- stage p0/p1: two-flop column synchroniser ----
  logic [3:0] col_sync_p0, col_sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_sync_p0 <= 4'hF;
      col_sync_p1 <= 4'hF;
    end else begin
      col_sync_p0 <= kp_col;
      col_sync_p1 <= col_sync_p0;
    end
  end

  // ---- scan timing: each row driven for SCAN_DIV cycles ----
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       row_idx;
  logic             sample, frame_done;

  assign kp_row     = ~(4'b0001 << row_idx);
  // Sampling on the last cycle of a row leaves room for settling plus the
  // two-cycle synchroniser delay.
  assign sample     = (div_cnt == DIV_LAST);
  assign frame_done = sample && (row_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      row_idx <= 2'd0;
    end else if (sample) begin
      div_cnt <= '0;
      row_idx <= row_idx + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---- frame accumulator ----
  logic [3:0] row_hits;
  logic [1:0] acc_cnt, sum_cnt;
  logic [3:0] acc_code, sum_code;

  assign row_hits = ~col_sync_p1;
  assign sum_cnt  = merge_count(acc_cnt, row_hits);
  assign sum_code = (|row_hits) ? {row_idx, first_col(row_hits)} : acc_code;

  always_ff @(posedge clk) begin
    if (rst || frame_done) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (sample) begin
      acc_cnt  <= sum_cnt;
      acc_code <= sum_code;
    end
  end

  // ---- debounce FSM, advanced once per completed frame ----
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       cand, cand_n;
  logic             accept;
  logic             f_none, f_single;

  assign f_none   = (sum_cnt == 2'd0);
  assign f_single = (sum_cnt == 2'd1);
  assign cnt_inc  = cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cand  <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      cand  <= cand_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (f_single) begin
            cand_n  = sum_code;
            cnt_n   = CNT_W'(1);
            state_n = PRESS_CHK;
          end
        end
        PRESS_CHK: begin
          if (f_single && (sum_code == cand)) begin
            if (cnt_inc == CNT_DONE) begin
              state_n = HELD;
              accept  = 1'b1;
            end else begin
              cnt_n = cnt_inc;
            end
          end else if (f_single) begin
            cand_n = sum_code;
            cnt_n  = CNT_W'(1);
          end else begin
            state_n = IDLE;
          end
        end
        HELD: begin
          // Rollover and continued holding are ignored: no auto-repeat.
          if (f_none) begin
            cnt_n   = CNT_W'(1);
            state_n = REL_CHK;
          end
        end
        default: begin  // REL_CHK
          if (f_none) begin
            if (cnt_inc == CNT_DONE) state_n = IDLE;
            else                     cnt_n   = cnt_inc;
          end else begin
            state_n = HELD;
          end
        end
      endcase
    end
  end

  // ---- registered outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_valid <= 1'b0;
      btn_char  <= 8'h00;
      key_held  <= 1'b0;
    end else begin
      btn_valid <= accept;
      if (accept) btn_char <= key_map(cand);
      key_held  <= (state_n == HELD) || (state_n == REL_CHK);
    end
  end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder with SCAN_DIV=4, DEBOUNCE_FRAMES=3
// (one frame = 16 cycles). A behavioural keypad matrix drives kp_col from
// kp_row and the set of pressed keys.
module tb_keypad_scan_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] kp_col;
  logic [3:0] kp_row;
  logic       btn_valid;
  logic [7:0] btn_char;
  logic       key_held;

  logic [15:0] keys;
  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  int dbl = 0;
  logic prev_v = 1'b0;
  int p;

  logic [7:0] kmap [16] = '{8'h31, 8'h32, 8'h33, 8'h2B, 8'h34, 8'h35, 8'h36, 8'h2D,
                            8'h37, 8'h38, 8'h39, 8'h2A, 8'h43, 8'h30, 8'h08, 8'h3D};

  keypad_scan_encoder #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .kp_col(kp_col), .kp_row(kp_row),
    .btn_valid(btn_valid), .btn_char(btn_char), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Matrix model: a column is pulled low when a pressed key in it sits on the driven row.
  always_comb begin
    kp_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp_row[r]) kp_col[c] = 1'b0;
  end

  // Pulse monitor: counts pulses and flags back-to-back valid cycles.
  always @(negedge clk) begin
    if (btn_valid === 1'b1 && prev_v) dbl <= dbl + 1;
    if (btn_valid === 1'b1) pulses <= pulses + 1;
    prev_v <= (btn_valid === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Moves to the negedge of the first cycle of a frame (row 0 just driven).
  task automatic align();
    int n = 0;
    while (kp_row !== 4'b0111 && n < 64) begin @(negedge clk); n++; end
    while (kp_row === 4'b0111 && n < 64) begin @(negedge clk); n++; end
    chk("align", {31'b0, n < 64}, 32'd1);
  endtask

  initial begin
    rst  = 1'b1;
    keys = 16'h0;
    // 1. reset state and row scan sequence
    cyc(2);
    chk("rst_row", kp_row, 4'b1110);
    chk("rst_valid", btn_valid, 0);
    chk("rst_char", btn_char, 8'h00);
    chk("rst_held", key_held, 0);
    rst = 1'b0;
    cyc(3);  chk("scan_r0", kp_row, 4'b1110);
    cyc(1);  chk("scan_r1", kp_row, 4'b1101);
    cyc(4);  chk("scan_r2", kp_row, 4'b1011);
    cyc(4);  chk("scan_r3", kp_row, 4'b0111);
    cyc(4);  chk("scan_wrap", kp_row, 4'b1110);

    // 2. hold '5' for 12 frames, then release
    align();
    keys = 16'h1 << 5;
    p = pulses;
    cyc(47); chk("s2_early", btn_valid, 0);
    cyc(1);  chk("s2_pulse", btn_valid, 1);
    chk("s2_char", btn_char, 8'h35);
    chk("s2_held", key_held, 1);
    cyc(9*16);
    chk("s2_one_pulse", pulses - p, 1);
    keys = 16'h0;
    cyc(47); chk("s2_rel_held", key_held, 1);
    cyc(1);  chk("s2_rel_done", key_held, 0);

    // 3. bouncing '=' then steady press
    p = pulses;
    keys = 16'h8000; cyc(16);
    keys = 16'h0;    cyc(16);
    keys = 16'h8000; cyc(16);
    keys = 16'h0;    cyc(16);
    keys = 16'h8000;
    cyc(47); chk("s3_no_pulse", pulses - p, 0);
    chk("s3_early", btn_valid, 0);
    cyc(1);  chk("s3_pulse", btn_valid, 1);
    chk("s3_char", btn_char, 8'h3D);
    keys = 16'h0; cyc(48);

    // 4. '1'+'2' together, then '1' alone
    p = pulses;
    keys = 16'h0003; cyc(80);
    chk("s4_multi", pulses - p, 0);
    keys = 16'h0001;
    cyc(47); chk("s4_early", btn_valid, 0);
    cyc(1);  chk("s4_pulse", btn_valid, 1);
    chk("s4_char", btn_char, 8'h31);
    keys = 16'h0; cyc(48);

    // 5. '+' accepted, short release ignored, full release then re-press
    keys = 16'h0008;
    cyc(48); chk("s5_pulse1", btn_valid, 1);
    chk("s5_char1", btn_char, 8'h2B);
    p = pulses;
    keys = 16'h0;    cyc(32);
    keys = 16'h0008; cyc(80);
    chk("s5_no_repeat", pulses - p, 1);
    chk("s5_still_held", key_held, 1);
    keys = 16'h0; cyc(48);
    chk("s5_released", key_held, 0);
    keys = 16'h0008;
    cyc(47); chk("s5_early", btn_valid, 0);
    cyc(1);  chk("s5_pulse2", btn_valid, 1);
    chk("s5_char2", btn_char, 8'h2B);
    keys = 16'h0;
    cyc(1);  chk("s5_count", pulses - p, 2);
    cyc(47);

    // 6. full key map
    for (int k = 0; k < 16; k++) begin
      keys = 16'h1 << k;
      cyc(48);
      chk($sformatf("map_valid_%0d", k), btn_valid, 1);
      chk($sformatf("map_char_%0d", k), btn_char, kmap[k]);
      keys = 16'h0;
      cyc(48);
    end

    // reset while '9' is held
    keys = 16'h1 << 10;
    cyc(48); chk("s6_pulse9", btn_valid, 1);
    cyc(16); chk("s6_in_held", key_held, 1);
    rst = 1'b1;
    cyc(2);
    chk("s6_rst_held", key_held, 0);
    chk("s6_rst_valid", btn_valid, 0);
    chk("s6_rst_char", btn_char, 8'h00);
    chk("s6_rst_row", kp_row, 4'b1110);
    rst = 1'b0;
    cyc(47); chk("s6_early", btn_valid, 0);
    chk("s6_early_held", key_held, 0);
    cyc(1);  chk("s6_pulse", btn_valid, 1);
    chk("s6_char", btn_char, 8'h39);
    keys = 16'h0;
    cyc(2);
    chk("no_double_pulse", dbl, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
